// File: rtl/fifo_push_scheduler.sv
// fifo_push_scheduler: arbitrates NREQ producers onto a FIFO's single write
// port (round-robin), gates consumer pops, tracks occupancy so the FIFO can
// never overflow/underflow, runs a drain-to-empty flush sequence and keeps
// saturating full/empty event counters.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req, req_data   per-producer push request (held until granted) and data
//   pop_req         consumer pop request
//   flush           pulse that starts the flush sequence
//   gnt             registered one-hot grant
//   push_o/datain_o registered FIFO push and write data
//   pop_o           registered FIFO pop
//   occ             committed occupancy (0..DEPTH)
//   full_o/empty_o  combinational decode of occ
//   flush_done      one-cycle pulse when a flush completes
//   full_events/empty_events  saturating event counters
module fifo_push_scheduler #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned LOG2DEPTH = 3,
    parameter int unsigned NREQ      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic                    pop_req,
    input  logic                    flush,
    output logic [NREQ-1:0]         gnt,
    output logic                    push_o,
    output logic [WIDTH-1:0]        datain_o,
    output logic                    pop_o,
    output logic [LOG2DEPTH:0]      occ,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    flush_done,
    output logic [15:0]             full_events,
    output logic [15:0]             empty_events
);

    localparam int unsigned OCC_W = LOG2DEPTH + 1;
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NREQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FLUSH  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               push_q, push_d;
    logic [WIDTH-1:0]   datain_q, datain_d;
    logic               pop_q, pop_d;
    logic               flush_done_q, flush_done_d;
    logic [CNT_W-1:0]   full_events_q, full_events_d;
    logic [CNT_W-1:0]   empty_events_q, empty_events_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    int unsigned        arb_idx;
    logic               push_ok;
    logic               pop_ok;

    // Round-robin search starting at rr_ptr; first asserted request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        arb_idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            arb_idx = int'(rr_ptr_q) + k;
            if (arb_idx >= NREQ) begin
                arb_idx = arb_idx - NREQ;
            end
            if (!win_found && req[PTR_W'(arb_idx)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(arb_idx);
            end
        end
    end

    // Next-state, push/pop decisions and registered output values.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        gnt_d          = '0;
        push_d         = 1'b0;
        datain_d       = datain_q;
        pop_d          = 1'b0;
        flush_done_d   = 1'b0;
        push_ok        = 1'b0;
        pop_ok         = 1'b0;

        case (state_q)
            ST_NORMAL: begin
                // The cycle that accepts flush makes no push/pop decision,
                // so the flush drains exactly the occupancy seen at entry.
                if (flush) begin
                    state_d = ST_FLUSH;
                end else begin
                    pop_ok  = pop_req && (occ_q != '0);
                    push_ok = win_found && ((occ_q < DEPTH_OCC) || pop_ok);
                end
            end
            ST_FLUSH: begin
                pop_ok = (occ_q != '0);
                if (occ_q == '0) begin
                    state_d      = ST_NORMAL;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = ST_NORMAL;
        endcase

        if (push_ok) begin
            gnt_d[win_idx] = 1'b1;
            push_d         = 1'b1;
            datain_d       = req_data[32'(win_idx) * WIDTH +: WIDTH];
            rr_ptr_d       = (win_idx == LAST_PTR) ? '0 : win_idx + PTR_W'(1);
        end
        pop_d = pop_ok;

        occ_d = occ_q + OCC_W'(push_ok) - OCC_W'(pop_ok);

        // Event counters count edges into full/empty and stick at all-ones.
        full_events_d = full_events_q;
        if ((occ_q != DEPTH_OCC) && (occ_d == DEPTH_OCC) && (full_events_q != CNT_MAX)) begin
            full_events_d = full_events_q + CNT_W'(1);
        end
        empty_events_d = empty_events_q;
        if ((occ_q != '0) && (occ_d == '0) && (empty_events_q != CNT_MAX)) begin
            empty_events_d = empty_events_q + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_NORMAL;
            rr_ptr_q       <= '0;
            occ_q          <= '0;
            gnt_q          <= '0;
            push_q         <= 1'b0;
            datain_q       <= '0;
            pop_q          <= 1'b0;
            flush_done_q   <= 1'b0;
            full_events_q  <= '0;
            empty_events_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            occ_q          <= occ_d;
            gnt_q          <= gnt_d;
            push_q         <= push_d;
            datain_q       <= datain_d;
            pop_q          <= pop_d;
            flush_done_q   <= flush_done_d;
            full_events_q  <= full_events_d;
            empty_events_q <= empty_events_d;
        end
    end

    assign gnt          = gnt_q;
    assign push_o       = push_q;
    assign datain_o     = datain_q;
    assign pop_o        = pop_q;
    assign occ          = occ_q;
    assign flush_done   = flush_done_q;
    assign full_events  = full_events_q;
    assign empty_events = empty_events_q;
    assign full_o       = (occ_q == DEPTH_OCC);
    assign empty_o      = (occ_q == '0);

endmodule

// File: tb/tb_fifo_push_scheduler.sv
// Directed testbench for fifo_push_scheduler: expected grants/data are queued
// when requests are driven and compared as push_o pulses appear.
module tb_fifo_push_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        pop_req;
    logic        flush;
    logic [3:0]  gnt;
    logic        push_o;
    logic [7:0]  datain_o;
    logic        pop_o;
    logic [3:0]  occ;
    logic        full_o;
    logic        empty_o;
    logic        flush_done;
    logic [15:0] full_events;
    logic [15:0] empty_events;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   push_cnt    = 0;
    int   pop_cnt     = 0;

    fifo_push_scheduler #(
        .WIDTH(8), .DEPTH(8), .LOG2DEPTH(3), .NREQ(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .pop_req(pop_req), .flush(flush), .gnt(gnt), .push_o(push_o),
        .datain_o(datain_o), .pop_o(pop_o), .occ(occ), .full_o(full_o),
        .empty_o(empty_o), .flush_done(flush_done),
        .full_events(full_events), .empty_events(empty_events)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the grant expected for producer i, carrying its current data.
    task automatic exp_grant(input int i);
        exp_t e;
        e.g = 4'(1 << i);
        e.d = req_data[i*8 +: 8];
        sb_q.push_back(e);
    endtask

    // One clock; sample 1ns after the edge and score any push.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (pop_o) pop_cnt++;
        if (push_o) begin
            push_cnt++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_push", {28'd0, gnt}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_gnt", {28'd0, gnt}, {28'd0, e.g});
                chk("sb_data", {24'd0, datain_o}, {24'd0, e.d});
            end
        end else begin
            chk("gnt_idle", {28'd0, gnt}, 32'd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        pop_req  = 1'b0;
        flush    = 1'b0;
        step();
        step();
        // Reset state
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_push", 32'(push_o), 32'd0);
        chk("rst_pop", 32'(pop_o), 32'd0);
        chk("rst_data", 32'(datain_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_fdone", 32'(flush_done), 32'd0);
        chk("rst_fev", 32'(full_events), 32'd0);
        chk("rst_eev", 32'(empty_events), 32'd0);
        rst = 1'b0;

        // Fill: all requesters, 8 round-robin grants then stop at full
        req = 4'b1111;
        for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) exp_grant(i);
        push_cnt = 0;
        for (int c = 0; c < 12; c++) step();
        chk("fill_pushes", 32'(push_cnt), 32'd8);
        chk("fill_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("fill_occ", 32'(occ), 32'd8);
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_fev", 32'(full_events), 32'd1);
        chk("fill_data_hold", 32'(datain_o), 32'h44);

        // Full with simultaneous pop: slot freed by the pop
        req = 4'b0100; pop_req = 1'b1;
        exp_grant(2);
        step();
        chk("fullpop_pop", 32'(pop_o), 32'd1);
        chk("fullpop_push", 32'(push_o), 32'd1);
        chk("fullpop_occ", 32'(occ), 32'd8);
        chk("fullpop_fev", 32'(full_events), 32'd1);

        // Drain to empty
        req = '0;
        for (int c = 0; c < 8; c++) step();
        chk("drain_occ", 32'(occ), 32'd0);
        chk("drain_empty", 32'(empty_o), 32'd1);
        chk("drain_eev", 32'(empty_events), 32'd1);
        step();
        chk("drain_nopop_at_0", 32'(pop_o), 32'd0);

        // Empty, no bypass: push accepted, pop refused in same cycle
        req = 4'b0001;
        exp_grant(0);
        step();
        chk("nobypass_pop", 32'(pop_o), 32'd0);
        chk("nobypass_occ", 32'(occ), 32'd1);
        req = '0;
        step();
        chk("nobypass_pop2", 32'(pop_o), 32'd1);
        chk("nobypass_occ2", 32'(occ), 32'd0);
        chk("nobypass_eev", 32'(empty_events), 32'd2);
        pop_req = 1'b0;

        // Build occ=5 (rr_ptr is 1 here)
        req = 4'b1111;
        exp_grant(1); exp_grant(2); exp_grant(3); exp_grant(0); exp_grant(1);
        for (int c = 0; c < 5; c++) step();
        chk("pre_flush_occ", 32'(occ), 32'd5);

        // Flush with all requesters active: no grants, 5 pops, then done
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_entry_occ", 32'(occ), 32'd5);
        chk("flush_entry_pop", 32'(pop_o), 32'd0);
        pop_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("flush_pop", 32'(pop_o), 32'd1);
            chk("flush_occ", 32'(occ), 32'(4 - i));
            chk("flush_done_early", 32'(flush_done), 32'd0);
        end
        step();
        chk("flush_done", 32'(flush_done), 32'd1);
        chk("flush_pops", 32'(pop_cnt), 32'd5);
        chk("flush_end_occ", 32'(occ), 32'd0);
        chk("flush_eev", 32'(empty_events), 32'd3);
        exp_grant(2);
        step();
        chk("flush_done_pulse", 32'(flush_done), 32'd0);
        chk("post_flush_occ", 32'(occ), 32'd1);

        // Move rr_ptr to 0, then fairness with req=1010 and steady pops
        req = 4'b1000;
        exp_grant(3);
        step();
        req = 4'b1010; pop_req = 1'b1;
        for (int r = 0; r < 3; r++) begin exp_grant(1); exp_grant(3); end
        for (int c = 0; c < 6; c++) step();
        chk("rr_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("rr_occ", 32'(occ), 32'd2);
        req = '0; pop_req = 1'b0;

        // occ=3, enter flush, reset while flushing
        req = 4'b0001;
        exp_grant(0);
        step();
        req = '0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("pre_rst_occ", 32'(occ), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_occ", 32'(occ), 32'd0);
        chk("midrst_push", 32'(push_o), 32'd0);
        chk("midrst_pop", 32'(pop_o), 32'd0);
        chk("midrst_fev", 32'(full_events), 32'd0);
        chk("midrst_eev", 32'(empty_events), 32'd0);
        chk("midrst_fdone", 32'(flush_done), 32'd0);
        // Back in NORMAL with rr_ptr=0
        req = 4'b1111;
        exp_grant(0);
        step();
        chk("postrst_occ", 32'(occ), 32'd1);

        // Saturation: occ to 7, pin counter at max, then cross into full
        exp_grant(1); exp_grant(2); exp_grant(3); exp_grant(0); exp_grant(1); exp_grant(2);
        for (int c = 0; c < 6; c++) step();
        req = '0;
        chk("sat_occ7", 32'(occ), 32'd7);
        force dut.full_events_q = 16'hFFFF;
        step();
        release dut.full_events_q;
        chk("sat_forced", 32'(full_events), 32'hFFFF);
        req = 4'b1111;
        exp_grant(3);
        step();
        req = '0;
        chk("sat_full", 32'(full_o), 32'd1);
        chk("sat_hold", 32'(full_events), 32'hFFFF);
        step();
        chk("end_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_push_scheduler.md
# fifo_push_scheduler

Front-end scheduler for the 8-entry FIFO. It shares the FIFO's single write port among NREQ producers using round-robin arbitration and gates consumer pop requests. It tracks occupancy itself, so it never overflows or underflows the FIFO, and it provides a flush sequence. It also exports saturating full/empty event counters that the stimulus and reward logic use as coverage metrics.

## Interface
- WIDTH, 8, data width; matches the FIFO data width
- DEPTH, 8, FIFO depth in entries
- LOG2DEPTH, 3, log2(DEPTH); occupancy is LOG2DEPTH+1 bits
- NREQ, 4, number of producers; must be at least 2
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-producer push request; level-sensitive, held until granted
- req_data  in  NREQ*WIDTH  producer data; producer i uses bits [i*WIDTH +: WIDTH]
- pop_req  in  1  consumer pop request
- flush  in  1  pulse; starts the flush sequence
- gnt  out  NREQ  registered one-hot grant; at most one bit set per cycle
- push_o  out  1  registered push to the FIFO
- datain_o  out  WIDTH  registered data to the FIFO; valid when push_o=1
- pop_o  out  1  registered pop to the FIFO
- occ  out  LOG2DEPTH+1  committed occupancy
- full_o, empty_o  out  1  combinational decode: occ==DEPTH, occ==0
- flush_done  out  1  one-cycle pulse when a flush completes
- full_events, empty_events  out  16  saturating event counters

## Operation
- The FSM has two states, NORMAL and FLUSH. Reset enters NORMAL.
- Pop decision in NORMAL (pop_ok): pop_ok = pop_req && occ>0. There is no bypass: a pop is never issued when occ==0, even if a push is issued in the same cycle.
- Push decision in NORMAL (push_ok): push_ok = |req && (occ<DEPTH || pop_ok). A simultaneous pop frees the slot.
- Arbitration:
  - The search starts at rr_ptr and proceeds in order rr_ptr, rr_ptr+1, … modulo NREQ. The first asserted req wins.
  - When a grant is issued to producer i, rr_ptr becomes (i+1) mod NREQ.
  - When no grant is issued, rr_ptr holds.
- Registered outputs on the edge after the decision:
  - gnt has only the winner's bit set.
  - push_o=1 and datain_o is the winner's data.
  - pop_o equals pop_ok.
  - When push_o=0, datain_o holds its previous value.
- Occupancy update: occ_next = occ + push_ok − pop_ok. Arithmetic is done at LOG2DEPTH+1 bits, and occ never leaves the range 0..DEPTH.
- NORMAL → FLUSH: taken when flush=1.
  - In FLUSH, no grants are issued and req is ignored.
  - pop_ok = occ>0, independent of pop_req.
- FLUSH → NORMAL:
  - Taken on the cycle occ==0 is observed. flush_done pulses on that same edge.
  - A flush asserted while occ==0 enters FLUSH, then completes on the following cycle.
- flush while already in FLUSH has no effect.
- Event counters:
  - full_events increments when occ transitions from a value below DEPTH to DEPTH.
  - empty_events increments when occ transitions from a nonzero value to 0.
  - Both counters saturate at 0xFFFF.
  - Reset does not count as an event.
- Reset clears all state and outputs: gnt=0, push_o=0, pop_o=0, datain_o=0, occ=0, rr_ptr=0, flush_done=0, both counters=0, FSM in NORMAL. Consequently empty_o=1 and full_o=0.
- Reset mid-operation discards the in-flight decision and any flush in progress. The FIFO is reset on the same rst, so the two stay consistent.

## Timing
- Request-to-push latency: a request sampled at edge N produces gnt, push_o and datain_o during cycle N+1. The FIFO writes at edge N+2.
- gnt is valid for exactly one cycle per accepted word. After seeing gnt, a producer may change req_data or drop req on the next edge.
- occ updates on the same edge as push_o/pop_o. occ therefore leads the FIFO's own count by one cycle, which is intended.
- Throughput: one push and one pop per cycle at most. When all NREQ requesters are continuously active, each is granted once every NREQ cycles.
- full_o and empty_o are combinational from occ. There is no path from req or pop_req to any output without passing through a register.

## Test plan
- Fill test:
  - Stimulus: reset, then all four req=1 and pop_req=0 for 12 cycles.
  - Required grants: gnt sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000, after which grants stop. Exactly 8 push_o pulses are issued.
  - Required status: occ=8, full_o=1, full_events=1.
- Full with simultaneous pop: with occ=8, req[2]=1 and pop_req=1 for one cycle → gnt=0100, push_o=1, pop_o=1, occ stays 8, full_events unchanged.
- Empty with no bypass: with occ=0, pop_req=1 and req[0]=1 in the same cycle → pop_o=0, push_o=1, occ=1. On the next cycle, with req dropped, pop_o=1, occ=0 and empty_events increments by 1.
- Flush:
  - Stimulus: with occ=5 and req=1111, pulse flush.
  - Required: gnt=0 for the whole flush; 5 consecutive pop_o pulses; occ reaches 0.
  - Required: flush_done pulses once, FSM returns to NORMAL, and granting resumes from the rr_ptr value held before the flush.
- Round-robin fairness: req=1010 held for 6 grants → gnt alternates 0010, 1000, 0010, 1000, 0010, 1000.
- Mid-operation reset and saturation:
  - Assert rst during a flush with occ=3 → next cycle occ=0, push_o=0, pop_o=0, counters=0, flush_done=0.
  - Force full_events to 0xFFFF, then trigger another full transition → full_events stays 0xFFFF.
